// File: rtl/color_track_pkg.sv
// Shared types and width helpers for the colour centroid tracker.
package color_track_pkg;

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2
  } channel_e;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  localparam int NUM_CH   = 3;
  localparam int NUM_JOBS = 6;

  // Identifies which centroid coordinate a divider pass is producing.
  typedef struct packed {
    channel_e ch;
    logic     isY;
  } div_job_t;

  // Registered status flags presented alongside the centroid results.
  typedef struct packed {
    logic [NUM_CH-1:0] found;
    logic              valid;
    logic              busy;
    logic              overrun;
  } result_flags_t;

  function automatic int xWidth(input int frameW);
    return $clog2(frameW);
  endfunction

  function automatic int yWidth(input int frameH);
    return $clog2(frameH);
  endfunction

  function automatic int countWidth(input int frameW, input int frameH);
    return $clog2(frameW * frameH + 1);
  endfunction

  function automatic int sumWidth(input int frameW, input int frameH);
    int xw;
    int yw;
    xw = xWidth(frameW);
    yw = yWidth(frameH);
    return countWidth(frameW, frameH) + ((xw > yw) ? xw : yw);
  endfunction

  // Pass order is Rx, Ry, Gx, Gy, Bx, By: channel in the upper bits, axis in bit 0.
  function automatic div_job_t jobDecode(input logic [2:0] idx);
    div_job_t j;
    j.ch  = channel_e'(idx[2:1]);
    j.isY = idx[0];
    return j;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring serial divider: one load cycle, then WIDTH shift/subtract steps.
// done and quotient are valid during the final step cycle; a zero divisor yields 0.
module serial_divider #(
  parameter int WIDTH = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_quoNext;

  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_den};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_quoNext = {r_quo[WIDTH-2:0], w_ge};
  assign done      = r_run && (r_cnt == CNT_W'(1));
  assign quotient  = (r_den == '0) ? '0 : w_quoNext;

  // Load operands on start, otherwise run one restoring step per cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_den <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_den <= divisor;
      r_cnt <= CNT_W'(WIDTH);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo <= w_quoNext;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/color_centroid_accum.sv
// Per-frame colour mask accumulator with time-shared centroid divider.
module color_centroid_accum
  import color_track_pkg::*;
#(
  parameter  int FRAME_W = 320,
  parameter  int FRAME_H = 240,
  parameter  int ADDR_W  = 18,
  localparam int X_W     = xWidth(FRAME_W),
  localparam int Y_W     = yWidth(FRAME_H),
  localparam int COUNT_W = countWidth(FRAME_W, FRAME_H),
  localparam int SUM_W   = sumWidth(FRAME_W, FRAME_H)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [2:0]            d_in,
  input  logic                  we_in,
  input  logic [COUNT_W-1:0]    min_count,
  output logic [3*X_W-1:0]      cent_x,
  output logic [3*Y_W-1:0]      cent_y,
  output logic [3*COUNT_W-1:0]  pix_count,
  output logic [2:0]            found,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);

  acc_state_e          r_accState;
  logic [ADDR_W-1:0]   r_expected;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COUNT_W-1:0]  r_count [NUM_CH];
  logic [SUM_W-1:0]    r_sumX  [NUM_CH];
  logic [SUM_W-1:0]    r_sumY  [NUM_CH];
  logic                r_frameErr;

  div_state_e          r_divState;
  logic [2:0]          r_job;
  logic                r_kick;
  logic [COUNT_W-1:0]  r_snapCount [NUM_CH];
  logic [SUM_W-1:0]    r_snapSumX  [NUM_CH];
  logic [SUM_W-1:0]    r_snapSumY  [NUM_CH];
  logic [X_W-1:0]      r_qx [NUM_CH];
  logic [Y_W-1:0]      r_qy [NUM_CH];
  logic [3*X_W-1:0]    r_centX;
  logic [3*Y_W-1:0]    r_centY;
  logic [3*COUNT_W-1:0] r_pixCount;
  result_flags_t       r_flags;

  logic                w_addrZero;
  logic                w_accept;
  logic                w_seqErr;
  logic                w_frameEnd;
  logic [X_W-1:0]      w_px;
  logic [Y_W-1:0]      w_py;
  logic [COUNT_W-1:0]  w_cntNext [NUM_CH];
  logic [SUM_W-1:0]    w_sxNext  [NUM_CH];
  logic [SUM_W-1:0]    w_syNext  [NUM_CH];
  div_job_t            w_job;
  logic [SUM_W-1:0]    w_dividend;
  logic [SUM_W-1:0]    w_divisor;
  logic [SUM_W-1:0]    w_quo;
  logic                w_divDone;
  logic [X_W-1:0]      w_quoX;
  logic [Y_W-1:0]      w_quoY;

  assign w_addrZero = (addr_in == '0);
  assign w_accept   = we_in && (w_addrZero || (r_accState == ACCUM && addr_in == r_expected));
  assign w_seqErr   = we_in && (r_accState == ACCUM) && !w_addrZero && (addr_in != r_expected);
  assign w_frameEnd = w_accept && (addr_in == LAST_ADDR);
  assign w_px       = w_addrZero ? '0 : r_x;
  assign w_py       = w_addrZero ? '0 : r_y;

  // Next accumulator values for the current pixel; address 0 restarts from empty sums.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_cntNext[c] = (w_addrZero ? '0 : r_count[c]) + COUNT_W'(d_in[c]);
      w_sxNext[c]  = (w_addrZero ? '0 : r_sumX[c]) + (d_in[c] ? SUM_W'(w_px) : '0);
      w_syNext[c]  = (w_addrZero ? '0 : r_sumY[c]) + (d_in[c] ? SUM_W'(w_py) : '0);
    end
  end

  // Frame accumulator: tracks raster position and flags out-of-sequence addresses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_accState <= IDLE;
      r_expected <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_frameErr <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_count[c] <= '0;
        r_sumX[c]  <= '0;
        r_sumY[c]  <= '0;
      end
    end else begin
      r_frameErr <= w_seqErr;
      if (w_seqErr) begin
        r_accState <= IDLE;
      end else if (w_accept) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_count[c] <= w_cntNext[c];
          r_sumX[c]  <= w_sxNext[c];
          r_sumY[c]  <= w_syNext[c];
        end
        if (w_frameEnd) begin
          r_accState <= IDLE;
        end else begin
          r_accState <= ACCUM;
          r_expected <= addr_in + ADDR_W'(1);
          if (w_px == X_W'(FRAME_W - 1)) begin
            r_x <= '0;
            r_y <= w_py + Y_W'(1);
          end else begin
            r_x <= w_px + X_W'(1);
            r_y <= w_py;
          end
        end
      end
    end
  end

  assign w_job      = jobDecode(r_job);
  assign w_dividend = w_job.isY ? r_snapSumY[w_job.ch] : r_snapSumX[w_job.ch];
  assign w_divisor  = SUM_W'(r_snapCount[w_job.ch]);
  assign w_quoX     = (|w_quo[SUM_W-1:X_W]) ? '1 : w_quo[X_W-1:0];
  assign w_quoY     = (|w_quo[SUM_W-1:Y_W]) ? '1 : w_quo[Y_W-1:0];

  serial_divider #(
    .WIDTH(SUM_W)
  ) u_divider (
    .clock   (clock),
    .reset   (reset),
    .start   (r_kick),
    .dividend(w_dividend),
    .divisor (w_divisor),
    .quotient(w_quo),
    .done    (w_divDone)
  );

  // Divider sequencer: snapshots a finished frame, runs six divisions, publishes results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_divState <= DIV_IDLE;
      r_job      <= '0;
      r_kick     <= 1'b0;
      r_centX    <= '0;
      r_centY    <= '0;
      r_pixCount <= '0;
      r_flags    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_snapCount[c] <= '0;
        r_snapSumX[c]  <= '0;
        r_snapSumY[c]  <= '0;
        r_qx[c]        <= '0;
        r_qy[c]        <= '0;
      end
    end else begin
      r_kick          <= 1'b0;
      r_flags.valid   <= 1'b0;
      r_flags.overrun <= w_frameEnd && (r_divState != DIV_IDLE);
      case (r_divState)
        DIV_IDLE: begin
          if (w_frameEnd) begin
            for (int c = 0; c < NUM_CH; c++) begin
              r_snapCount[c] <= w_cntNext[c];
              r_snapSumX[c]  <= w_sxNext[c];
              r_snapSumY[c]  <= w_syNext[c];
            end
            r_job        <= '0;
            r_kick       <= 1'b1;
            r_flags.busy <= 1'b1;
            r_divState   <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          if (w_divDone) begin
            if (w_job.isY) r_qy[w_job.ch] <= w_quoY;
            else           r_qx[w_job.ch] <= w_quoX;
            if (r_job == 3'(NUM_JOBS - 1)) begin
              r_divState <= DIV_DONE;
            end else begin
              r_job  <= r_job + 3'd1;
              r_kick <= 1'b1;
            end
          end
        end
        DIV_DONE: begin
          for (int c = 0; c < NUM_CH; c++) begin
            r_centX[c*X_W +: X_W]             <= r_qx[c];
            r_centY[c*Y_W +: Y_W]             <= r_qy[c];
            r_pixCount[c*COUNT_W +: COUNT_W]  <= r_snapCount[c];
            r_flags.found[c] <= (r_snapCount[c] != '0) && (r_snapCount[c] >= min_count);
          end
          r_flags.valid <= 1'b1;
          r_flags.busy  <= 1'b0;
          r_divState    <= DIV_IDLE;
        end
        default: r_divState <= DIV_IDLE;
      endcase
    end
  end

  assign cent_x       = r_centX;
  assign cent_y       = r_centY;
  assign pix_count    = r_pixCount;
  assign found        = r_flags.found;
  assign result_valid = r_flags.valid;
  assign busy         = r_flags.busy;
  assign overrun      = r_flags.overrun;
  assign frame_err    = r_frameErr;

endmodule

// File: tb/tb_color_centroid_accum.sv
// Directed bench for color_centroid_accum on an 8x4 frame.
module tb_color_centroid_accum;

  localparam int FW      = 8;
  localparam int FH      = 4;
  localparam int AW      = 18;
  localparam int XW      = 3;
  localparam int YW      = 2;
  localparam int CW      = 6;
  localparam int LATENCY = 61;

  logic              clock = 1'b0;
  logic              reset;
  logic [AW-1:0]     addr_in;
  logic [2:0]        d_in;
  logic              we_in;
  logic [CW-1:0]     min_count;
  logic [3*XW-1:0]   cent_x;
  logic [3*YW-1:0]   cent_y;
  logic [3*CW-1:0]   pix_count;
  logic [2:0]        found;
  logic              result_valid;
  logic              busy;
  logic              frame_err;
  logic              overrun;

  int errors = 0;
  int checks = 0;
  int lat;
  int nValid;

  color_centroid_accum #(
    .FRAME_W(FW),
    .FRAME_H(FH),
    .ADDR_W (AW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .addr_in     (addr_in),
    .d_in        (d_in),
    .we_in       (we_in),
    .min_count   (min_count),
    .cent_x      (cent_x),
    .cent_y      (cent_y),
    .pix_count   (pix_count),
    .found       (found),
    .result_valid(result_valid),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel strobe; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input int addr, input logic [2:0] mask);
    we_in   = 1'b1;
    addr_in = AW'(addr);
    d_in    = mask;
    @(posedge clock);
    #1;
    we_in   = 1'b0;
  endtask

  function automatic logic [2:0] pattern(input int mode, input int a);
    case (mode)
      0:       return 3'b001;
      1:       return 3'b010;
      3:       return {a[2], 1'b0, a[0]};
      4:       return (a == 13) ? 3'b010 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  task automatic runFrame(input int mode);
    for (int a = 0; a < FW * FH; a++) applyStimulus(a, pattern(mode, a));
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (result_valid !== 1'b1 && cycles < 300) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic countValid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (result_valid === 1'b1) n++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [31:0] cx, input logic [31:0] cy,
                             input logic [31:0] pc, input logic [31:0] fd);
    checkOutput({tag, "_cent_x"}, 32'(cent_x), cx);
    checkOutput({tag, "_cent_y"}, 32'(cent_y), cy);
    checkOutput({tag, "_pix_count"}, 32'(pix_count), pc);
    checkOutput({tag, "_found"}, 32'(found), fd);
  endtask

  initial begin
    reset     = 1'b1;
    we_in     = 1'b0;
    addr_in   = '0;
    d_in      = '0;
    min_count = CW'(1);
    #1;
    checkResult("reset", 0, 0, 0, 0);
    checkOutput("reset_valid", 32'(result_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_ferr", 32'(frame_err), 0);
    checkOutput("reset_ovr", 32'(overrun), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] test 1: full red frame");
    runFrame(0);
    checkOutput("t1_busy", 32'(busy), 1);
    waitResult(lat);
    checkOutput("t1_latency", lat, LATENCY);
    checkResult("t1", {3'd0, 3'd0, 3'd3}, {2'd0, 2'd0, 2'd1}, {6'd0, 6'd0, 6'd32}, 3'b001);
    checkOutput("t1_busy_done", 32'(busy), 0);
    @(posedge clock);
    #1;
    checkOutput("t1_valid_pulse", 32'(result_valid), 0);

    $display("[TB] test 2: single green pixel at addr 13");
    min_count = CW'(2);
    runFrame(4);
    waitResult(lat);
    checkOutput("t2_latency", lat, LATENCY);
    checkResult("t2", {3'd0, 3'd5, 3'd0}, {2'd0, 2'd1, 2'd0}, {6'd0, 6'd1, 6'd0}, 3'b000);
    min_count = CW'(1);
    runFrame(4);
    waitResult(lat);
    checkOutput("t2b_found", 32'(found), 3'b010);

    $display("[TB] test 3: address sequence error");
    for (int a = 0; a < 10; a++) applyStimulus(a, 3'b111);
    applyStimulus(11, 3'b111);
    checkOutput("t3_frame_err", 32'(frame_err), 1);
    @(posedge clock);
    #1;
    checkOutput("t3_frame_err_pulse", 32'(frame_err), 0);
    countValid(80, nValid);
    checkOutput("t3_no_result", nValid, 0);
    runFrame(3);
    waitResult(lat);
    checkOutput("t3_latency", lat, LATENCY);
    checkResult("t3", {3'd5, 3'd0, 3'd4}, {2'd1, 2'd0, 2'd1}, {6'd16, 6'd0, 6'd16}, 3'b101);

    $display("[TB] test 4: back-to-back frames");
    runFrame(0);
    runFrame(1);
    checkOutput("t4_overrun", 32'(overrun), 1);
    waitResult(lat);
    checkOutput("t4_latency", lat, LATENCY - FW * FH);
    checkResult("t4", {3'd0, 3'd0, 3'd3}, {2'd0, 2'd0, 2'd1}, {6'd0, 6'd0, 6'd32}, 3'b001);
    countValid(100, nValid);
    checkOutput("t4_single_result", nValid, 0);
    checkOutput("t4_hold_pix", 32'(pix_count), {6'd0, 6'd0, 6'd32});

    $display("[TB] test 5: reset during division");
    runFrame(1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("t5_busy_before", 32'(busy), 1);
    reset = 1'b1;
    #1;
    checkResult("t5_reset", 0, 0, 0, 0);
    checkOutput("t5_reset_busy", 32'(busy), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    countValid(80, nValid);
    checkOutput("t5_no_result", nValid, 0);
    runFrame(1);
    waitResult(lat);
    checkOutput("t5_latency", lat, LATENCY);
    checkResult("t5", {3'd0, 3'd3, 3'd0}, {2'd0, 2'd1, 2'd0}, {6'd0, 6'd32, 6'd0}, 3'b010);

    $display("[TB] test 6: empty frame");
    runFrame(2);
    waitResult(lat);
    checkOutput("t6_latency", lat, LATENCY);
    checkResult("t6", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/color_centroid_accum.md
Name: color_centroid_accum

Overview:
Downstream consumer of the per-pixel colour-threshold stage. Takes its 3-bit R/G/B mask pulses with a linear pixel address and accumulates per-channel hit count and coordinate sums over one frame. At frame end it runs a shared serial divider to produce per-channel centroid (x,y), then presents the results for the tracking/AXI register layer.

Parameters:
FRAME_W, 320, pixels per line; address = y*FRAME_W + x.
FRAME_H, 240, lines per frame.
ADDR_W, 18, width of addr_in.

Ports:
clock  in  1  single clock domain.
reset  in  1  asynchronous, active-high reset.
addr_in  in  ADDR_W  linear pixel address from the threshold stage.
d_in  in  3  mask: bit0 red, bit1 green, bit2 blue.
we_in  in  1  one-cycle pixel-valid strobe.
min_count  in  COUNT_W  minimum hits for a channel to be reported found.
cent_x  out  3*X_W  packed {blue, green, red} centroid x.
cent_y  out  3*Y_W  packed {blue, green, red} centroid y.
pix_count  out  3*COUNT_W  packed per-channel hit count.
found  out  3  per-channel (count != 0 && count >= min_count).
result_valid  out  1  one-cycle pulse when outputs update.
busy  out  1  high while divider runs.
frame_err  out  1  one-cycle pulse on address sequence error.
overrun  out  1  one-cycle pulse when a frame completes while busy.

Behaviour:
- Clock and reset are fixed: one clock, named clock; reset is asynchronous and active-high, named reset.
- Derived widths: X_W = clog2(FRAME_W), Y_W = clog2(FRAME_H), COUNT_W = clog2(FRAME_W*FRAME_H+1), SUM_W = COUNT_W + max(X_W,Y_W). Defaults are 9, 8, 17, 26.
- Reset clears every output, accumulator, snapshot and FSM to 0 or IDLE, immediately and asynchronously.
- Accumulator FSM has states IDLE and ACCUM.
  - Pixel accepted only when we_in=1. Back-to-back strobes are legal, one pixel per cycle.
  - addr_in==0 in any state: clear counts and sums, accumulate this pixel at x=0, y=0, go to ACCUM, expected=1.
  - In ACCUM, addr_in==expected: for each set mask bit, count += 1, sum_x += x, sum_y += y. Then x increments and wraps at FRAME_W-1, incrementing y.
  - addr_in != expected and != 0: frame_err pulse next cycle, go to IDLE, discard partial sums.
  - Strobes in IDLE with addr_in != 0 are ignored silently.
  - Accepted addr_in == FRAME_W*FRAME_H-1 ends the frame: accumulate it, copy final counts and sums to snapshot registers, go to IDLE.
- Divider FSM has states DIV_IDLE, DIV_RUN and DIV_DONE.
  - Frame end with divider idle: start DIV_RUN the next cycle; busy=1.
  - Frame end while busy: overrun pulse, that frame's snapshot dropped, running division unaffected.
  - Accumulation continues independently during DIV_RUN, so the next frame is never stalled.
- Division: one restoring serial divider, SUM_W iterations plus 1 load cycle per quotient.
  - Fixed order: Rx, Ry, Gx, Gy, Bx, By. Quotient is floor(sum/count).
  - count==0 forces quotient 0 with no special timing; latency stays fixed.
  - Total latency from the cycle after the last pixel strobe to result_valid is 6*(SUM_W+1)+1 cycles (163 at defaults).
- DIV_DONE: register cent_x, cent_y, pix_count and found, using the min_count value sampled at that cycle. Pulse result_valid, busy=0, return to DIV_IDLE.
- Outputs hold until the next result_valid.

Decomposition:
- Package color_track_pkg: channel index enum (CH_RED=0, CH_GREEN=1, CH_BLUE=2), the derived-width localparam functions, and the packed result struct.
- One sub-module, serial_divider (parameter WIDTH; ports start, dividend, divisor, quotient, done), instantiated once and time-shared.

Test Plan:
1. FRAME_W=8, FRAME_H=4; 32 strobes, addr 0..31, d_in=001 every cycle. Expect result_valid after 6*(9+1)+1=61 cycles; red count=32, cx=3 (112/32), cy=1 (48/32), found=001, other channels 0.
2. Same sizing; only addr 13 has d_in=010; min_count=2. Expect green count=1, cx=5, cy=1, found bit1=0; with min_count=1 on rerun, found=010.
3. Addresses 0..9 then 11. Expect frame_err pulse, no result_valid. A following clean frame gives a correct result.
4. Two complete back-to-back frames (64 consecutive strobes). Expect overrun pulse at the second frame end, exactly one result_valid carrying frame-1 values.
5. Reset asserted 20 cycles into DIV_RUN. Expect all outputs 0 immediately, busy=0, no result_valid. The next full frame completes normally.
6. Full frame with d_in=000. Expect counts 0, centroids 0, found=000, result_valid at nominal latency.
